// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO slice.
// Holds the UART data width, default FIFO sizing and busy-wait timeout,
// the drain FSM state encoding and the width of the busy-wait timer.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int BUSY_TIMEOUT_DEF = 4;
    localparam int TIMER_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3
    } state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Circular byte store for the UART transmit FIFO.
// Ports:
//   clk_50m, rst : clock and asynchronous active-high reset
//   push, wr_data: store wr_data at the write pointer (ignored when full)
//   pop          : advance the read pointer (ignored when empty)
//   rd_data      : byte at the read pointer (combinational)
//   count        : occupancy 0..DEPTH; empty / full derived from it
module uart_tx_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   empty,
    output logic                   full
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_EMPTY = (DEPTH_LOG2 + 1)'(0);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   push_s, pop_s;

    assign empty   = (count_q == CNT_EMPTY);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Guard the requests so a careless caller cannot corrupt pointers.
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents after reset are irrelevant because count is zero.
    always_ff @(posedge clk_50m) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and drain controller in front of a UART transmitter.
// Ports:
//   clk_50m, rst       : clock and asynchronous active-high reset
//   wr_data/wr_valid   : producer byte and valid; wr_ready = !full
//   uart_din/uart_wr_en: registered byte and one-cycle load strobe to the UART
//   uart_tx_busy       : UART transmitter busy flag
//   count/empty/full   : FIFO occupancy status
//   overflow           : one-cycle pulse per cycle a byte is offered while full
//   busy_timeout       : one-cycle pulse when the UART never raised busy after a load
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [UART_DATA_W-1:0] uart_din,
    output logic                   uart_wr_en,
    input  logic                   uart_tx_busy,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   busy_timeout
);

    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [UART_DATA_W-1:0] din_q, din_d;
    logic                   wr_en_q, wr_en_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_timeout_q, busy_timeout_d;
    logic [UART_DATA_W-1:0] rd_data_s;
    logic                   empty_s, full_s, push_s, pop_s;

    // Decisions use pre-edge status, so a full FIFO never pushes in the
    // same cycle it pops, and a freshly pushed byte is popped one edge later.
    assign push_s = wr_valid && !full_s;
    assign pop_s  = (state_q == ST_IDLE) && !empty_s && !uart_tx_busy;

    uart_tx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk_50m (clk_50m),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (wr_data),
        .rd_data (rd_data_s),
        .count   (count),
        .empty   (empty_s),
        .full    (full_s)
    );

    assign empty        = empty_s;
    assign full         = full_s;
    assign wr_ready     = !full_s;
    assign uart_din     = din_q;
    assign uart_wr_en   = wr_en_q;
    assign overflow     = overflow_q;
    assign busy_timeout = busy_timeout_q;

    // Drain FSM next state, busy-wait timer and registered output values.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        din_d          = din_q;
        wr_en_d        = (state_q == ST_LOAD);
        overflow_d     = wr_valid && full_s;
        busy_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    din_d   = rd_data_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    // UART never acknowledged the load; give up on this byte.
                    busy_timeout_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            din_q          <= 8'h00;
            wr_en_q        <= 1'b0;
            overflow_q     <= 1'b0;
            busy_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            din_q          <= din_d;
            wr_en_q        <= wr_en_d;
            overflow_q     <= overflow_d;
            busy_timeout_q <= busy_timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a simple UART stand-in that
// latches each strobed byte and stays busy for a programmable number of cycles.
module tb_uart_tx_fifo;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] uart_din;
    logic       uart_wr_en;
    logic       uart_tx_busy;
    logic [4:0] count;
    logic       empty, full, overflow, busy_timeout;

    logic       busy_force = 1'b0;
    logic       stub_en = 1'b0;
    logic       stub_busy = 1'b0;
    int         stub_cnt = 0;
    int         stub_len = 10;
    int         wr_en_cnt = 0;
    logic [7:0] rx_q [$];

    int checks = 0;
    int errors = 0;

    assign uart_tx_busy = stub_en ? stub_busy : busy_force;

    uart_tx_fifo dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .busy_timeout (busy_timeout)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample strobe before the edge, advance the UART stand-in after it.
    task automatic tick;
        logic       we;
        logic [7:0] d;
        @(negedge clk_50m);
        we = uart_wr_en;
        d  = uart_din;
        @(posedge clk_50m);
        #1;
        if (stub_en) begin
            if (stub_cnt != 0) stub_cnt--;
            if (we) begin
                rx_q.push_back(d);
                stub_cnt = stub_len;
            end
            stub_busy = (stub_cnt != 0);
        end
        if (uart_wr_en) wr_en_cnt++;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rx(input string name, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, rx_q.size(), n);
    endtask

    task automatic settle;
        int k = 0;
        while (stub_busy && k < 200) begin
            tick();
            k++;
        end
        repeat (4) tick();
    endtask

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic [4:0] cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] got;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), 5'(i + 1), (i == 15), 1'b0};
        end
        vecs[16] = '{1'b1, 8'h10, 5'd16, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_wr_en", uart_wr_en, 0);
        chk("rst_din", uart_din, 8'h00);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", busy_timeout, 0);
        wr_en_cnt = 0;
        repeat (100) tick();
        chk("idle_no_wr_en", wr_en_cnt, 0);

        // Single byte latency: push edge N, pop N+1, strobe N+2..N+3
        stub_en = 1'b1;
        stub_len = 10;
        push(8'hA5);
        chk("lat_count_n", count, 1);
        chk("lat_wr_en_n", uart_wr_en, 0);
        tick();
        chk("lat_count_n1", count, 0);
        chk("lat_din_n1", uart_din, 8'hA5);
        chk("lat_wr_en_n1", uart_wr_en, 0);
        tick();
        chk("lat_wr_en_n2", uart_wr_en, 1);
        chk("lat_din_n2", uart_din, 8'hA5);
        tick();
        chk("lat_wr_en_n3", uart_wr_en, 0);
        wait_rx("lat_rx_size", 1, 20);
        got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF;
        chk("lat_rx_byte", got, 8'hA5);
        settle();

        // Fill to full with busy held, then overflow (table driven)
        stub_en = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            tick();
            chk($sformatf("fill%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("fill%0d_full", i), full, vecs[i].full);
            chk($sformatf("fill%0d_wr_ready", i), wr_ready, !vecs[i].full);
            chk($sformatf("fill%0d_empty", i), empty, 0);
            chk($sformatf("fill%0d_overflow", i), overflow, vecs[i].ovf);
            chk($sformatf("fill%0d_wr_en", i), uart_wr_en, 0);
        end
        wr_valid = 1'b0;
        rx_q.delete();
        stub_busy = 1'b0;
        stub_cnt = 0;
        stub_en = 1'b1;
        wait_rx("drain_rx_size", 16, 1000);
        repeat (60) tick();
        chk("drain_rx_size_final", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
            chk($sformatf("drain_byte%0d", i), got, i);
        end
        chk("drain_empty", empty, 1);
        settle();

        // Simultaneous push and pop at count 1
        stub_en = 1'b0;
        busy_force = 1'b1;
        rx_q.delete();
        push(8'h11);
        chk("pp_count_pre", count, 1);
        busy_force = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'h22;
        tick();
        wr_valid = 1'b0;
        chk("pp_count", count, 1);
        chk("pp_din", uart_din, 8'h11);
        stub_busy = 1'b0;
        stub_cnt = 0;
        stub_en = 1'b1;
        wait_rx("pp_rx_size", 2, 100);
        got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF;
        chk("pp_rx0", got, 8'h11);
        got = (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF;
        chk("pp_rx1", got, 8'h22);
        settle();

        // Busy never rises: timeout after four WAIT_BUSY cycles
        stub_en = 1'b0;
        busy_force = 1'b1;
        push(8'h33);
        push(8'h44);
        busy_force = 1'b0;
        tick();
        chk("to_pop_din", uart_din, 8'h33);
        chk("to_pop_count", count, 1);
        tick();
        chk("to_wr_en", uart_wr_en, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to_quiet%0d", i), busy_timeout, 0);
        end
        tick();
        chk("to_pulse", busy_timeout, 1);
        tick();
        chk("to_pulse_end", busy_timeout, 0);
        chk("to_next_din", uart_din, 8'h44);
        chk("to_next_count", count, 0);
        tick();
        chk("to_next_wr_en", uart_wr_en, 1);
        repeat (10) tick();

        // Reset while bytes are queued and one is on the line
        rx_q.delete();
        stub_len = 40;
        stub_busy = 1'b0;
        stub_cnt = 0;
        stub_en = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        wait_rx("rst_mid_rx1", 1, 20);
        chk("rst_mid_count_pre", count, 4);
        rst = 1'b1;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_wr_en", uart_wr_en, 0);
        chk("rst_mid_empty", empty, 1);
        tick();
        rst = 1'b0;
        wr_en_cnt = 0;
        repeat (20) tick();
        chk("rst_mid_no_wr_en", wr_en_cnt, 0);
        chk("rst_mid_still_busy", stub_busy, 1);
        push(8'h66);
        begin
            int k = 0;
            while (stub_busy && k < 100) begin
                tick();
                k++;
            end
        end
        chk("rst_mid_wait_busy", wr_en_cnt, 0);
        wait_rx("rst_mid_rx2", 2, 50);
        got = (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF;
        chk("rst_mid_new_byte", got, 8'h66);
        got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF;
        chk("rst_mid_first_byte", got, 8'h50);
        settle();
        chk("rst_mid_rx_final", rx_q.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
